// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX ping-pong buffer control slice.
// The write-enable logic imports FULL_THRESH_DEF so both sides agree on the full guard.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        BUF_FREE,
        BUF_FILL,
        BUF_READY
    } buf_state_t;

    typedef enum logic {
        ST_FILL,
        ST_STALL
    } ctrl_state_t;

    localparam int         LEN_W           = 10;
    localparam int         DROP_W          = 16;
    localparam logic [9:0] FULL_THRESH_DEF = 10'd1020;

    function automatic logic [DROP_W-1:0] sat_inc_drop(input logic [DROP_W-1:0] value);
        return (value == '1) ? value : value + DROP_W'(1);
    endfunction

endpackage

// File: rtl/uart_rx_pingpong_ctrl_if.sv
// Byte-source, write-side and reader-side signals of the ping-pong controller.
// master = the controller, slave = its environment (UART RX, write logic, reader).
interface uart_rx_pingpong_ctrl_if;
    import uart_rx_pkg::*;

    logic              uart_rx_vld;
    logic              uart_rx_vld_gated;
    logic              frame_ping_pong_flag;
    logic              frame_rdy;
    logic              frame_sel;
    logic [LEN_W-1:0]  frame_len;
    logic              frame_trunc;
    logic              frame_ack;
    logic              rx_drop_pulse;
    logic [DROP_W-1:0] rx_drop_cnt;

    modport master (
        input  uart_rx_vld,
        input  frame_ack,
        output uart_rx_vld_gated,
        output frame_ping_pong_flag,
        output frame_rdy,
        output frame_sel,
        output frame_len,
        output frame_trunc,
        output rx_drop_pulse,
        output rx_drop_cnt
    );

    modport slave (
        output uart_rx_vld,
        output frame_ack,
        input  uart_rx_vld_gated,
        input  frame_ping_pong_flag,
        input  frame_rdy,
        input  frame_sel,
        input  frame_len,
        input  frame_trunc,
        input  rx_drop_pulse,
        input  rx_drop_cnt
    );

endinterface

// File: rtl/uart_rx_idle_timer.sv
// Counts line-idle cycles after the last byte of a non-empty frame.
// timeout is only asserted while enable is high, so it never fires on an empty buffer.
module uart_rx_idle_timer #(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(1000)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LAST = TIMEOUT - CNT_W'(1);

    logic [CNT_W-1:0] idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (clear) begin
            idle_cnt <= '0;
        end else if (enable && (idle_cnt != '1)) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end

    assign timeout = enable && (idle_cnt == LAST);

endmodule

// File: rtl/uart_rx_pingpong_ctrl.sv
// Ping-pong sequencer: counts bytes into the current buffer, closes frames on idle or
// near-full, flips to the other buffer when free and hands closed frames out oldest first.
module uart_rx_pingpong_ctrl
    import uart_rx_pkg::*;
#(
    parameter int               CNT_W        = 16,
    parameter logic [CNT_W-1:0] IDLE_TIMEOUT = CNT_W'(1000),
    parameter logic [LEN_W-1:0] FULL_THRESH  = FULL_THRESH_DEF
) (
    input logic                     clk,
    input logic                     rst_n,
    uart_rx_pingpong_ctrl_if.master bus
);

    ctrl_state_t       state_q, state_d;
    logic              flag_q, flag_d, flag_n;
    buf_state_t        buf_st_q [2];
    buf_state_t        buf_st_d [2];
    logic [LEN_W-1:0]  len_q [2];
    logic [LEN_W-1:0]  len_d [2];
    logic [1:0]        trunc_q, trunc_d;
    logic              oldest_q, oldest_d;
    logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              drop_pulse_q, drop_pulse_d;
    logic              frame_rdy_q, frame_rdy_d;
    logic              frame_sel_q, frame_sel_d;
    logic [LEN_W-1:0]  frame_len_q, frame_len_d;
    logic              frame_trunc_q, frame_trunc_d;

    logic in_fill;
    logic byte_gated;
    logic close_full;
    logic frame_close;
    logic idle_en;
    logic idle_clear;
    logic idle_timeout;
    logic ack_ok;

    assign in_fill     = (state_q == ST_FILL);
    assign flag_n      = ~flag_q;
    assign byte_gated  = in_fill && bus.uart_rx_vld && (wr_cnt_q != FULL_THRESH);
    assign close_full  = in_fill && (wr_cnt_q == FULL_THRESH);
    assign idle_en     = in_fill && (wr_cnt_q != '0) && !close_full && !bus.uart_rx_vld;
    assign frame_close = close_full || idle_timeout;
    assign idle_clear  = byte_gated || frame_close;
    assign ack_ok      = bus.frame_ack && frame_rdy_q;

    uart_rx_idle_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (IDLE_TIMEOUT)
    ) u_idle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (idle_clear),
        .enable  (idle_en),
        .timeout (idle_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_FILL;
            flag_q        <= 1'b0;
            buf_st_q[0]   <= BUF_FREE;
            buf_st_q[1]   <= BUF_FREE;
            len_q[0]      <= '0;
            len_q[1]      <= '0;
            trunc_q       <= '0;
            oldest_q      <= 1'b0;
            wr_cnt_q      <= '0;
            drop_cnt_q    <= '0;
            drop_pulse_q  <= 1'b0;
            frame_rdy_q   <= 1'b0;
            frame_sel_q   <= 1'b0;
            frame_len_q   <= '0;
            frame_trunc_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flag_q        <= flag_d;
            buf_st_q      <= buf_st_d;
            len_q         <= len_d;
            trunc_q       <= trunc_d;
            oldest_q      <= oldest_d;
            wr_cnt_q      <= wr_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            drop_pulse_q  <= drop_pulse_d;
            frame_rdy_q   <= frame_rdy_d;
            frame_sel_q   <= frame_sel_d;
            frame_len_q   <= frame_len_d;
            frame_trunc_q <= frame_trunc_d;
        end
    end

    // The ack is applied before the close so a buffer freed this cycle can take the flip.
    always_comb begin
        state_d      = state_q;
        flag_d       = flag_q;
        buf_st_d     = buf_st_q;
        len_d        = len_q;
        trunc_d      = trunc_q;
        oldest_d     = oldest_q;
        wr_cnt_d     = wr_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        drop_pulse_d = 1'b0;

        if (ack_ok) begin
            buf_st_d[frame_sel_q] = BUF_FREE;
            oldest_d              = ~frame_sel_q;
        end

        case (state_q)
            ST_FILL: begin
                if (byte_gated) begin
                    wr_cnt_d = wr_cnt_q + LEN_W'(1);
                    if (buf_st_q[flag_q] == BUF_FREE) begin
                        buf_st_d[flag_q] = BUF_FILL;
                    end
                end
                if (frame_close) begin
                    buf_st_d[flag_q] = BUF_READY;
                    len_d[flag_q]    = wr_cnt_q;
                    trunc_d[flag_q]  = close_full;
                    wr_cnt_d         = '0;
                    if (buf_st_d[flag_n] != BUF_READY) begin
                        oldest_d = flag_q;
                    end
                    if (buf_st_d[flag_n] == BUF_FREE) begin
                        flag_d           = flag_n;
                        buf_st_d[flag_n] = BUF_FILL;
                    end else begin
                        state_d = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                if (bus.uart_rx_vld) begin
                    drop_pulse_d = 1'b1;
                    drop_cnt_d   = sat_inc_drop(drop_cnt_q);
                end
                if (ack_ok) begin
                    flag_d                = frame_sel_q;
                    buf_st_d[frame_sel_q] = BUF_FILL;
                    state_d               = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        frame_rdy_d = (buf_st_d[0] == BUF_READY) || (buf_st_d[1] == BUF_READY);
        if ((buf_st_d[0] == BUF_READY) && (buf_st_d[1] == BUF_READY)) begin
            frame_sel_d = oldest_d;
        end else begin
            frame_sel_d = (buf_st_d[1] == BUF_READY);
        end
        frame_len_d   = len_d[frame_sel_d];
        frame_trunc_d = trunc_d[frame_sel_d];
    end

    assign bus.uart_rx_vld_gated    = byte_gated;
    assign bus.frame_ping_pong_flag = flag_q;
    assign bus.frame_rdy            = frame_rdy_q;
    assign bus.frame_sel            = frame_sel_q;
    assign bus.frame_len            = frame_len_q;
    assign bus.frame_trunc          = frame_trunc_q;
    assign bus.rx_drop_pulse        = drop_pulse_q;
    assign bus.rx_drop_cnt          = drop_cnt_q;

endmodule

// File: tb/tb_uart_rx_pingpong_ctrl.sv
// Bench for uart_rx_pingpong_ctrl: frame-level queue model checked every cycle,
// a table of frame scenarios, directed corner sequences and a randomized run.
module tb_uart_rx_pingpong_ctrl;
    import uart_rx_pkg::*;

    localparam int IT   = 50;
    localparam int FULL = 1020;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_rx_pingpong_ctrl_if bus ();

    uart_rx_pingpong_ctrl #(
        .CNT_W        (16),
        .IDLE_TIMEOUT (16'd50),
        .FULL_THRESH  (10'd1020)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int id;
        int len;
        int trunc;
    } frame_t;

    // Reference: closed frames are a FIFO; a buffer is free exactly when it is not queued.
    frame_t m_ready_q[$];
    int     m_cnt, m_sil, m_flag, m_stall, m_drops, m_pulse, m_gated;
    int     last_gated;

    typedef struct {
        int nbytes;
        int gap;
        bit ack;
        bit exp_rdy;
        bit exp_sel;
        int exp_len;
        bit exp_flag;
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_ready_q.delete();
        m_cnt   = 0;
        m_sil   = 0;
        m_flag  = 0;
        m_stall = 0;
        m_drops = 0;
        m_pulse = 0;
        m_gated = 0;
    endtask

    function automatic bit is_queued(input int id);
        foreach (m_ready_q[i]) if (m_ready_q[i].id == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input bit vld, input bit ack);
        frame_t f;
        int     freed;
        bit     acked, close_now, tr;
        freed   = 0;
        m_pulse = (vld && m_stall != 0) ? 1 : 0;
        m_gated = (vld && m_stall == 0 && m_cnt != FULL) ? 1 : 0;
        acked   = ack && (m_ready_q.size() > 0);
        if (acked) begin
            freed = m_ready_q[0].id;
            void'(m_ready_q.pop_front());
        end
        if (m_stall != 0) begin
            if (vld && m_drops < 65535) m_drops++;
            if (acked) begin
                m_stall = 0;
                m_flag  = freed;
            end
        end else begin
            close_now = 1'b0;
            tr        = 1'b0;
            if (m_cnt == FULL) begin
                close_now = 1'b1;
                tr        = 1'b1;
            end else if (m_gated != 0) begin
                m_cnt++;
                m_sil = 0;
            end else if (m_cnt != 0) begin
                if (m_sil == IT - 1) close_now = 1'b1;
                else m_sil++;
            end
            if (close_now) begin
                f.id    = m_flag;
                f.len   = m_cnt;
                f.trunc = tr;
                m_ready_q.push_back(f);
                m_cnt = 0;
                m_sil = 0;
                if (is_queued(1 - m_flag)) m_stall = 1;
                else m_flag = 1 - m_flag;
            end
        end
    endtask

    task automatic compare_model();
        checkOutput("flag", bus.frame_ping_pong_flag, m_flag);
        checkOutput("rdy", bus.frame_rdy, (m_ready_q.size() > 0) ? 1 : 0);
        if (m_ready_q.size() > 0) begin
            checkOutput("sel", bus.frame_sel, m_ready_q[0].id);
            checkOutput("len", bus.frame_len, m_ready_q[0].len);
            checkOutput("trunc", bus.frame_trunc, m_ready_q[0].trunc);
        end
        checkOutput("drop_cnt", bus.rx_drop_cnt, m_drops);
        checkOutput("drop_pulse", bus.rx_drop_pulse, m_pulse);
    endtask

    // One clock cycle: drive at negedge, check the combinational gate, check state after the edge.
    task automatic applyStimulus(input bit vld, input bit ack);
        @(negedge clk);
        bus.uart_rx_vld = vld;
        bus.frame_ack   = ack;
        #1;
        model_step(vld, ack);
        last_gated = bus.uart_rx_vld_gated;
        checkOutput("gated", last_gated, m_gated);
        @(posedge clk);
        #1;
        bus.uart_rx_vld = 1'b0;
        bus.frame_ack   = 1'b0;
        compare_model();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic send_frame(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (i < n - 1) idle_cycles(gap);
        end
        idle_cycles(IT);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.uart_rx_vld = 1'b0;
        bus.frame_ack   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_gated"}, bus.uart_rx_vld_gated, 0);
        checkOutput({tag, "_flag"}, bus.frame_ping_pong_flag, 0);
        checkOutput({tag, "_rdy"}, bus.frame_rdy, 0);
        checkOutput({tag, "_sel"}, bus.frame_sel, 0);
        checkOutput({tag, "_len"}, bus.frame_len, 0);
        checkOutput({tag, "_trunc"}, bus.frame_trunc, 0);
        checkOutput({tag, "_pulse"}, bus.rx_drop_pulse, 0);
        checkOutput({tag, "_dropcnt"}, bus.rx_drop_cnt, 0);
    endtask

    initial begin
        int  n;
        bit  burst;
        int  phase_left;

        vecs[0] = '{7, 2, 1'b0, 1'b1, 1'b0, 7, 1'b1};
        vecs[1] = '{9, 1, 1'b0, 1'b1, 1'b0, 7, 1'b1};
        vecs[2] = '{0, 0, 1'b1, 1'b1, 1'b1, 9, 1'b0};
        vecs[3] = '{0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0};
        vecs[4] = '{5, 3, 1'b0, 1'b1, 1'b0, 5, 1'b1};
        vecs[5] = '{0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b1};

        bus.uart_rx_vld = 1'b0;
        bus.frame_ack   = 1'b0;
        model_reset();
        #3;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] idle close of a 5-byte frame");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (i < 4) idle_cycles(19);
        end
        n = 0;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b0, 1'b0);
            n++;
            if (bus.frame_rdy) break;
        end
        checkOutput("t1_close_delay", n, IT);
        checkOutput("t1_rdy", bus.frame_rdy, 1);
        checkOutput("t1_sel", bus.frame_sel, 0);
        checkOutput("t1_len", bus.frame_len, 5);
        checkOutput("t1_trunc", bus.frame_trunc, 0);
        checkOutput("t1_flag", bus.frame_ping_pong_flag, 1);

        $display("[TB] forced close at the full threshold");
        do_reset();
        n = 0;
        for (int i = 1; i <= FULL + 1; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (last_gated != 0) n++;
        end
        checkOutput("t2_gated_count", n, FULL);
        checkOutput("t2_rdy", bus.frame_rdy, 1);
        checkOutput("t2_len", bus.frame_len, 10'h3FC);
        checkOutput("t2_trunc", bus.frame_trunc, 1);
        checkOutput("t2_flag", bus.frame_ping_pong_flag, 1);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (last_gated != 0) n++;
        end
        checkOutput("t2_buf2_gated", n, 4);

        $display("[TB] both buffers full, stall and recover");
        do_reset();
        send_frame(3, 1);
        send_frame(4, 1);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (last_gated != 0) n++;
        end
        checkOutput("t3_stall_gated", n, 0);
        checkOutput("t3_drop_cnt", bus.rx_drop_cnt, 3);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t3_flag", bus.frame_ping_pong_flag, 0);
        checkOutput("t3_sel", bus.frame_sel, 1);
        checkOutput("t3_len", bus.frame_len, 4);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t3_resume_gated", last_gated, 1);

        $display("[TB] table of frame scenarios");
        do_reset();
        foreach (vecs[v]) begin
            send_frame(vecs[v].nbytes, vecs[v].gap);
            if (vecs[v].ack) applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("tbl%0d_rdy", v), bus.frame_rdy, vecs[v].exp_rdy);
            checkOutput($sformatf("tbl%0d_flag", v), bus.frame_ping_pong_flag, vecs[v].exp_flag);
            if (vecs[v].exp_rdy) begin
                checkOutput($sformatf("tbl%0d_sel", v), bus.frame_sel, vecs[v].exp_sel);
                checkOutput($sformatf("tbl%0d_len", v), bus.frame_len, vecs[v].exp_len);
            end
        end

        $display("[TB] ack on the same cycle as a close");
        do_reset();
        send_frame(6, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (i < 2) idle_cycles(1);
        end
        idle_cycles(IT - 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t5_flag", bus.frame_ping_pong_flag, 0);
        checkOutput("t5_rdy", bus.frame_rdy, 1);
        checkOutput("t5_sel", bus.frame_sel, 1);
        checkOutput("t5_len", bus.frame_len, 3);
        checkOutput("t5_drop_cnt", bus.rx_drop_cnt, 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t5_gated", last_gated, 1);

        $display("[TB] asynchronous reset mid-frame");
        applyStimulus(1'b0, 1'b1);
        send_frame(2, 1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("t6_pre_flag", bus.frame_ping_pong_flag, 1);
        checkOutput("t6_pre_rdy", bus.frame_rdy, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_frame(4, 2);
        checkOutput("t6_len", bus.frame_len, 4);
        checkOutput("t6_sel", bus.frame_sel, 0);
        checkOutput("t6_flag", bus.frame_ping_pong_flag, 1);

        $display("[TB] randomized traffic against the model");
        do_reset();
        burst      = 1'b1;
        phase_left = 20;
        for (int c = 0; c < 5000; c++) begin
            if (phase_left == 0) begin
                burst      = ~burst;
                phase_left = burst ? $urandom_range(5, 40) : $urandom_range(10, 120);
            end
            phase_left--;
            applyStimulus(burst ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0),
                          $urandom_range(0, 59) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
